ctrl_frame_parser: RTL
======================

Name: ctrl_frame_parser

Overview:
Parametrised successor to the time-sync control receiver. Parses the 64-bit control AXIS stream frame by frame, filters on destination MAC, and decodes slot-ID and time-sync frames. Results are buffered and committed only when a frame ends cleanly, so errored frames (tuser) and runt frames never reach the output. Sits between the control-port MAC RX and the time-sync / slot-scheduler logic.

Parameters:
P_SLOT_ID_TYPE, 16'hff03, ethertype of slot-ID frames
P_SYNC_TYPE, 16'hff04, ethertype of time-sync frames
P_SLOT_ID_W, 2, slot-ID width (1..16)
P_LOCAL_MAC, 48'h00_0a_35_00_00_01, local MAC for the destination filter
P_MAC_FILTER_EN, 1, 1 = accept only P_LOCAL_MAC or broadcast; 0 = accept all
P_CNT_W, 16, width of the statistics counters
P_TS_CODE / P_STD_CODE / P_RET_CODE, 8'h66 / 8'h88 / 8'h55, sync message codes

Ports:
i_clk  in  1  clock
i_rst  in  1  reset (asynchronous, active-high)
s_axis_tvalid  in  1  control RX beat valid (no backpressure; every valid beat is consumed)
s_axis_tdata  in  64  beat data
s_axis_tlast  in  1  last beat of the frame
s_axis_tkeep  in  8  byte enables (ignored except on the last beat: must be non-zero)
s_axis_tuser  in  1  frame error, sampled on the tlast beat
o_slot_id  out  P_SLOT_ID_W  current slot ID (holds until the next commit)
o_slot_start  out  1  one-cycle pulse on slot-ID commit
o_recv_time_stamp / o_recv_std_time / o_recv_return_ts  out  64 each  committed values
o_recv_ts_valid / o_recv_std_valid / o_recv_return_valid  out  1 each  one-cycle commit pulses
o_good_cnt  out  P_CNT_W  committed frames, saturating
o_drop_cnt  out  P_CNT_W  dropped frames (tuser, runt, unknown code, tkeep=0), saturating

Behaviour:
- Reset values: all outputs 0; FSM in S_HDR0; shadow registers 0.
- Frame layout:
  - beat0 [63:16] = dest MAC.
  - beat1 [31:16] = ethertype; beat1 [P_SLOT_ID_W-1:0] = slot ID.
  - Sync frames only: beat2 [7:0] = message code; beat3 = 64-bit value.
  - Beats after beat3 are ignored.
- FSM: S_HDR0 -> S_HDR1 -> S_BODY -> S_DROP. Transitions happen only on valid beats; tvalid gaps hold state.
- S_HDR0, on a valid beat:
  - Latch the MAC match.
  - tlast on this beat -> runt: drop_cnt+1, stay in S_HDR0.
  - Otherwise go to S_HDR1.
- S_HDR1:
  - MAC mismatch, or ethertype not slot/sync -> S_DROP, no count (silent discard).
  - Slot type -> shadow slot ID.
  - Sync type -> S_BODY.
  - If tlast on this beat:
    - slot frame -> commit;
    - sync frame -> runt drop;
    - go to S_HDR0.
  - A slot frame longer than 2 beats goes to S_BODY and commits at its tlast.
- S_BODY:
  - beat2: latch the code; an unknown code marks the frame bad.
  - beat3: shadow the value.
  - At tlast: commit if the frame is good, otherwise drop_cnt+1; go to S_HDR0.
  - A sync frame whose tlast arrives before beat3 is a runt: drop.
- S_DROP: wait for tlast (no count), then go to S_HDR0.
- Commit conditions at the tlast beat: tuser=0 and tkeep != 0. Otherwise drop_cnt+1 and nothing is committed.
- Commit latency: exactly 1 cycle after the tlast beat.
  - The pulse output asserts for 1 cycle.
  - The value/ID registers update in the same cycle as the pulse.
  - good_cnt+1 in that cycle.
- Value outputs hold between commits; a new commit overwrites them.
- Back-to-back frames: tlast followed directly by the next beat0 must parse correctly with no dead cycle.
- Counters saturate at all-ones and do not wrap.
- Reset mid-frame: the frame is abandoned and no pulse is produced. After release, parsing resyncs only at the next beat after a tlast. Until a tlast is seen, beats are treated as S_DROP.

Test Plan:
1. Slot frame to P_LOCAL_MAC, ethertype ff03, slot bits = 2'b10, 2 beats, tuser=0 -> o_slot_start pulses 1 cycle after tlast, o_slot_id=2, good_cnt=1.
2. Sync frame: code 0x66, value 64'h0000_0123_4567_89AB, 4 beats -> o_recv_ts_valid pulses for 1 cycle with o_recv_time_stamp=64'h0000_0123_4567_89AB; std/return pulses stay low. Repeat with codes 0x88 and 0x55 -> the matching outputs pulse.
3. Same sync frame with tuser=1 on tlast -> no pulse, previous value held, drop_cnt=1. Code 0x77 -> drop_cnt=2.
4. Dest MAC 00_0a_35_00_00_02 with P_MAC_FILTER_EN=1 -> no pulse, no count change. Broadcast dest ff_ff_ff_ff_ff_ff -> commits.
5. 3-beat sync frame (runt), then a back-to-back valid slot frame with tvalid gaps inside -> drop_cnt+1, then the slot frame commits correctly.
6. Assert i_rst during beat2 of a sync frame; release, feed the remaining beats and then a good frame -> no commit for the broken frame, the good frame commits, counters restart from 0.

Source files
------------

// File: rtl/ctrl_frame_parser.sv
// ctrl_frame_parser -- control AXIS frame parser with MAC filter, slot-ID / time-sync decode and commit-on-clean-end.
// Revision 1.0
`default_nettype none

module ctrl_frame_parser #(
  parameter logic [15:0] P_SLOT_ID_TYPE  = 16'hff03,
  parameter logic [15:0] P_SYNC_TYPE     = 16'hff04,
  parameter int          P_SLOT_ID_W     = 2,
  parameter logic [47:0] P_LOCAL_MAC     = 48'h00_0a_35_00_00_01,
  parameter bit          P_MAC_FILTER_EN = 1'b1,
  parameter int          P_CNT_W         = 16,
  parameter logic [7:0]  P_TS_CODE       = 8'h66,
  parameter logic [7:0]  P_STD_CODE      = 8'h88,
  parameter logic [7:0]  P_RET_CODE      = 8'h55
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   s_axis_tvalid,
  input  logic [63:0]            s_axis_tdata,
  input  logic                   s_axis_tlast,
  input  logic [7:0]             s_axis_tkeep,
  input  logic                   s_axis_tuser,
  output logic [P_SLOT_ID_W-1:0] o_slot_id,
  output logic                   o_slot_start,
  output logic [63:0]            o_recv_time_stamp,
  output logic [63:0]            o_recv_std_time,
  output logic [63:0]            o_recv_return_ts,
  output logic                   o_recv_ts_valid,
  output logic                   o_recv_std_valid,
  output logic                   o_recv_return_valid,
  output logic [P_CNT_W-1:0]     o_good_cnt,
  output logic [P_CNT_W-1:0]     o_drop_cnt
);

  localparam logic [1:0] S_HDR0 = 2'd0;
  localparam logic [1:0] S_HDR1 = 2'd1;
  localparam logic [1:0] S_BODY = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  localparam logic [1:0] K_TS  = 2'd0;
  localparam logic [1:0] K_STD = 2'd1;
  localparam logic [1:0] K_RET = 2'd2;

  localparam logic [P_CNT_W-1:0] CNT_ONE = {{(P_CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]             state_q, state_d;
  logic                   hunt_q, hunt_d;
  logic                   mac_ok_q, mac_ok_d;
  logic                   is_sync_q, is_sync_d;
  logic [1:0]             bidx_q, bidx_d;
  logic                   bad_q, bad_d;
  logic [1:0]             kind_q, kind_d;
  logic [P_SLOT_ID_W-1:0] slot_sh_q, slot_sh_d;
  logic [63:0]            val_sh_q, val_sh_d;
  logic [P_SLOT_ID_W-1:0] slot_id_q, slot_id_d;
  logic                   slot_pls_q, slot_pls_d;
  logic [63:0]            ts_q, ts_d, std_q, std_d, ret_q, ret_d;
  logic                   ts_pls_q, ts_pls_d, std_pls_q, std_pls_d, ret_pls_q, ret_pls_d;
  logic [P_CNT_W-1:0]     good_q, good_d, drop_q, drop_d;

  logic        w_good_inc, w_drop_inc, w_end_ok, w_mac_hit, w_is_slot, w_is_sync;
  logic [47:0] w_mac;
  logic [63:0] w_val;

  assign w_mac     = s_axis_tdata[63:16];
  assign w_mac_hit = P_MAC_FILTER_EN ? ((w_mac == P_LOCAL_MAC) || (&w_mac)) : 1'b1;
  assign w_is_slot = (s_axis_tdata[31:16] == P_SLOT_ID_TYPE);
  assign w_is_sync = (s_axis_tdata[31:16] == P_SYNC_TYPE);
  assign w_end_ok  = !s_axis_tuser && (|s_axis_tkeep);
  // A 4-beat sync frame ends on the value beat itself, so the shadow is bypassed there.
  assign w_val     = (bidx_q == 2'd1) ? s_axis_tdata : val_sh_q;

  always_comb begin
    state_d    = state_q;
    hunt_d     = hunt_q;
    mac_ok_d   = mac_ok_q;
    is_sync_d  = is_sync_q;
    bidx_d     = bidx_q;
    bad_d      = bad_q;
    kind_d     = kind_q;
    slot_sh_d  = slot_sh_q;
    val_sh_d   = val_sh_q;
    slot_id_d  = slot_id_q;
    ts_d       = ts_q;
    std_d      = std_q;
    ret_d      = ret_q;
    slot_pls_d = 1'b0;
    ts_pls_d   = 1'b0;
    std_pls_d  = 1'b0;
    ret_pls_d  = 1'b0;
    w_good_inc = 1'b0;
    w_drop_inc = 1'b0;
    if (s_axis_tvalid) begin
      if (hunt_q) begin
        if (s_axis_tlast) begin
          hunt_d  = 1'b0;
          state_d = S_HDR0;
        end
      end else begin
        case (state_q)
          S_HDR0: begin
            mac_ok_d = w_mac_hit;
            if (s_axis_tlast) w_drop_inc = 1'b1;
            else              state_d    = S_HDR1;
          end
          S_HDR1: begin
            if (!mac_ok_q || !(w_is_slot || w_is_sync)) begin
              state_d = s_axis_tlast ? S_HDR0 : S_DROP;
            end else if (w_is_slot) begin
              is_sync_d = 1'b0;
              slot_sh_d = s_axis_tdata[P_SLOT_ID_W-1:0];
              if (s_axis_tlast) begin
                state_d = S_HDR0;
                if (w_end_ok) begin
                  slot_id_d  = s_axis_tdata[P_SLOT_ID_W-1:0];
                  slot_pls_d = 1'b1;
                  w_good_inc = 1'b1;
                end else begin
                  w_drop_inc = 1'b1;
                end
              end else begin
                state_d = S_BODY;
              end
            end else begin
              is_sync_d = 1'b1;
              bidx_d    = 2'd0;
              bad_d     = 1'b0;
              if (s_axis_tlast) begin
                state_d    = S_HDR0;
                w_drop_inc = 1'b1;
              end else begin
                state_d = S_BODY;
              end
            end
          end
          S_BODY: begin
            if (is_sync_q) begin
              if (bidx_q == 2'd0) begin
                bidx_d = 2'd1;
                bad_d  = 1'b0;
                if      (s_axis_tdata[7:0] == P_TS_CODE)  kind_d = K_TS;
                else if (s_axis_tdata[7:0] == P_STD_CODE) kind_d = K_STD;
                else if (s_axis_tdata[7:0] == P_RET_CODE) kind_d = K_RET;
                else                                      bad_d  = 1'b1;
              end else if (bidx_q == 2'd1) begin
                bidx_d   = 2'd2;
                val_sh_d = s_axis_tdata;
              end
            end
            if (s_axis_tlast) begin
              state_d = S_HDR0;
              if (w_end_ok && (!is_sync_q || (bidx_q != 2'd0 && !bad_q))) begin
                w_good_inc = 1'b1;
                if (!is_sync_q) begin
                  slot_id_d  = slot_sh_q;
                  slot_pls_d = 1'b1;
                end else begin
                  case (kind_q)
                    K_TS:    begin ts_d  = w_val; ts_pls_d  = 1'b1; end
                    K_STD:   begin std_d = w_val; std_pls_d = 1'b1; end
                    default: begin ret_d = w_val; ret_pls_d = 1'b1; end
                  endcase
                end
              end else begin
                w_drop_inc = 1'b1;
              end
            end
          end
          default: begin
            if (s_axis_tlast) state_d = S_HDR0;
          end
        endcase
      end
    end
    good_d = (w_good_inc && !(&good_q)) ? good_q + CNT_ONE : good_q;
    drop_d = (w_drop_inc && !(&drop_q)) ? drop_q + CNT_ONE : drop_q;
  end

  // hunt_q comes out of reset set: a reset may land mid-frame, so wait for a tlast to realign.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_HDR0;
      hunt_q     <= 1'b1;
      mac_ok_q   <= 1'b0;
      is_sync_q  <= 1'b0;
      bidx_q     <= 2'd0;
      bad_q      <= 1'b0;
      kind_q     <= K_TS;
      slot_sh_q  <= '0;
      val_sh_q   <= '0;
      slot_id_q  <= '0;
      slot_pls_q <= 1'b0;
      ts_q       <= '0;
      std_q      <= '0;
      ret_q      <= '0;
      ts_pls_q   <= 1'b0;
      std_pls_q  <= 1'b0;
      ret_pls_q  <= 1'b0;
      good_q     <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      hunt_q     <= hunt_d;
      mac_ok_q   <= mac_ok_d;
      is_sync_q  <= is_sync_d;
      bidx_q     <= bidx_d;
      bad_q      <= bad_d;
      kind_q     <= kind_d;
      slot_sh_q  <= slot_sh_d;
      val_sh_q   <= val_sh_d;
      slot_id_q  <= slot_id_d;
      slot_pls_q <= slot_pls_d;
      ts_q       <= ts_d;
      std_q      <= std_d;
      ret_q      <= ret_d;
      ts_pls_q   <= ts_pls_d;
      std_pls_q  <= std_pls_d;
      ret_pls_q  <= ret_pls_d;
      good_q     <= good_d;
      drop_q     <= drop_d;
    end
  end

  assign o_slot_id           = slot_id_q;
  assign o_slot_start        = slot_pls_q;
  assign o_recv_time_stamp   = ts_q;
  assign o_recv_std_time     = std_q;
  assign o_recv_return_ts    = ret_q;
  assign o_recv_ts_valid     = ts_pls_q;
  assign o_recv_std_valid    = std_pls_q;
  assign o_recv_return_valid = ret_pls_q;
  assign o_good_cnt          = good_q;
  assign o_drop_cnt          = drop_q;

endmodule

`default_nettype wire
